// File: rtl/logic_tile.sv
// logic_tile: basic programmable cell of the logic-cores fabric.
// Three independent functions share one clock/reset domain:
//   - a free-running LED counter with an enable-gated prescaler,
//   - a 4-input LUT whose 16-bit truth table is held in a register,
//   - a 2:1 multiplexer.
// The LUT and mux datapaths are combinational; only the counter and the
// LUT configuration hold state. Reset is synchronous and active-low.
module logic_tile #(
    parameter int          LED_WIDTH = 5,
    parameter int          PRESCALE  = 1,
    parameter logic [15:0] CFG_RESET = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cnt_en,
    output logic [LED_WIDTH-1:0] leds,
    input  logic                 cfg_we,
    input  logic [15:0]          cfg_data,
    input  logic [3:0]           lut_in,
    output logic                 lut_out,
    input  logic                 mux_sel,
    input  logic                 mux_i0,
    input  logic                 mux_i1,
    output logic                 mux_out
);

    // Prescaler needs at least one bit even when PRESCALE is 1, in which
    // case it simply stays at 0 and every enabled edge is a wrap edge.
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]      prescale_cnt;
    logic [LED_WIDTH-1:0] led_cnt;
    logic [15:0]          cfg;
    logic                 ps_wrap;

    // Increment is due on the enabled edge where the prescaler reaches its last value.
    assign ps_wrap = cnt_en && (prescale_cnt == PS_LAST);

    // Prescaler and LED counter; both hold while cnt_en is low.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            prescale_cnt <= '0;
            led_cnt      <= '0;
        end else if (cnt_en) begin
            if (ps_wrap) begin
                prescale_cnt <= '0;
                led_cnt      <= led_cnt + LED_WIDTH'(1);  // wraps modulo 2^LED_WIDTH
            end else begin
                prescale_cnt <= prescale_cnt + PS_W'(1);
            end
        end
    end

    // LUT configuration register; reset takes priority over a write on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg <= CFG_RESET;
        end else if (cfg_we) begin
            cfg <= cfg_data;
        end
    end

    assign leds = led_cnt;

    // LUT read: lut_in indexes the truth table directly (bit 0 for 4'b0000).
    assign lut_out = cfg[lut_in];

    // Mux is fully combinational and independent of clk/rst_n.
    assign mux_out = mux_sel ? mux_i1 : mux_i0;

endmodule

// File: tb/tb_logic_tile.sv
// Directed self-checking bench for logic_tile. Two instances share all
// inputs: u_dut uses PRESCALE=1, u_ps uses PRESCALE=4. Inputs are changed
// 1 time unit after a rising edge, outputs are sampled at the same point.
module tb_logic_tile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_en = 1'b0;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_data = 16'h0000;
    logic [3:0]  lut_in = 4'h0;
    logic        mux_sel = 1'b0;
    logic        mux_i0 = 1'b0;
    logic        mux_i1 = 1'b0;

    logic [4:0]  leds, leds_ps;
    logic        lut_out, lut_out_ps;
    logic        mux_out, mux_out_ps;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic_tile #(.LED_WIDTH(5), .PRESCALE(1), .CFG_RESET(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .leds(leds),
        .cfg_we(cfg_we), .cfg_data(cfg_data), .lut_in(lut_in), .lut_out(lut_out),
        .mux_sel(mux_sel), .mux_i0(mux_i0), .mux_i1(mux_i1), .mux_out(mux_out)
    );

    logic_tile #(.LED_WIDTH(5), .PRESCALE(4), .CFG_RESET(16'h0000)) u_ps (
        .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .leds(leds_ps),
        .cfg_we(cfg_we), .cfg_data(cfg_data), .lut_in(lut_in), .lut_out(lut_out_ps),
        .mux_sel(mux_sel), .mux_i0(mux_i0), .mux_i1(mux_i1), .mux_out(mux_out_ps)
    );

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int edges);
        rst_n = 1'b0;
        repeat (edges) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cnt_en   = 1'b1;
        cfg_we   = 1'b1;
        cfg_data = 16'hFFFF;
        do_reset(2);
        cfg_we   = 1'b0;
        cnt_en   = 1'b0;
        #1;
        n_checks++;
        if (leds !== 5'd0) begin
            $display("FAIL reset_leds: got %0d expected 0", leds);
            n_fail++;
        end
        n_checks++;
        if (leds_ps !== 5'd0) begin
            $display("FAIL reset_leds_ps: got %0d expected 0", leds_ps);
            n_fail++;
        end
        for (int i = 0; i < 16; i++) begin
            lut_in = 4'(i);
            #1;
            n_checks++;
            if (lut_out !== 1'b0) begin
                $display("FAIL reset_lut[%0d]: got %b expected 0", i, lut_out);
                n_fail++;
            end
        end
    endtask

    task automatic test_counter();
        int exp;
        do_reset(1);
        cnt_en = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            tick();
            exp = i % 32;
            n_checks++;
            if (leds !== 5'(exp)) begin
                $display("FAIL counter_step%0d: got %0d expected %0d", i, leds, exp);
                n_fail++;
            end
        end
        cnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (leds !== 5'd1) begin
                $display("FAIL counter_hold%0d: got %0d expected 1", i, leds);
                n_fail++;
            end
        end
    endtask

    task automatic test_prescaler();
        int exp;
        do_reset(1);
        cnt_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp = i / 4;
            n_checks++;
            if (leds_ps !== 5'(exp)) begin
                $display("FAIL prescale_edge%0d: got %0d expected %0d", i, leds_ps, exp);
                n_fail++;
            end
        end
        // Disabled edges must hold both counter and prescaler phase.
        cnt_en = 1'b0;
        repeat (5) tick();
        cnt_en = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (leds_ps !== 5'd3) begin
            $display("FAIL prescale_hold: got %0d expected 3", leds_ps);
            n_fail++;
        end
        tick();
        n_checks++;
        if (leds_ps !== 5'd4) begin
            $display("FAIL prescale_resume: got %0d expected 4", leds_ps);
            n_fail++;
        end
        cnt_en = 1'b0;
    endtask

    task automatic test_lut();
        logic exp;
        do_reset(1);
        lut_in = 4'h0;
        #1;
        n_checks++;
        if (lut_out !== 1'b0) begin
            $display("FAIL lut_reset_cfg: got %b expected 0", lut_out);
            n_fail++;
        end
        cfg_we = 1'b1;
        cfg_data = 16'h8001;
        tick();
        cfg_we = 1'b0;
        lut_in = 4'hF;
        #1;
        n_checks++;
        if (lut_out !== 1'b1) begin
            $display("FAIL lut_8001_in15: got %b expected 1", lut_out);
            n_fail++;
        end
        lut_in = 4'h0;
        #1;
        n_checks++;
        if (lut_out !== 1'b1) begin
            $display("FAIL lut_8001_in0: got %b expected 1", lut_out);
            n_fail++;
        end
        lut_in = 4'b0101;
        #1;
        n_checks++;
        if (lut_out !== 1'b0) begin
            $display("FAIL lut_8001_in5: got %b expected 0", lut_out);
            n_fail++;
        end
        cfg_we = 1'b1;
        cfg_data = 16'h6996;
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            lut_in = 4'(i);
            #1;
            exp = i[0] ^ i[1] ^ i[2] ^ i[3];
            n_checks++;
            if (lut_out !== exp) begin
                $display("FAIL lut_xor[%0d]: got %b expected %b", i, lut_out, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back();
        // cfg_we held over three edges: last value (16'h00FF) wins.
        cfg_we = 1'b1;
        cfg_data = 16'h1234;
        tick();
        cfg_data = 16'hFF00;
        tick();
        cfg_data = 16'h00FF;
        tick();
        cfg_we = 1'b0;
        lut_in = 4'd7;
        #1;
        n_checks++;
        if (lut_out !== 1'b1) begin
            $display("FAIL b2b_in7: got %b expected 1", lut_out);
            n_fail++;
        end
        lut_in = 4'd8;
        #1;
        n_checks++;
        if (lut_out !== 1'b0) begin
            $display("FAIL b2b_in8: got %b expected 0", lut_out);
            n_fail++;
        end
    endtask

    task automatic test_mux();
        mux_i0 = 1'b0; mux_i1 = 1'b1; mux_sel = 1'b0;
        #1;
        n_checks++;
        if (mux_out !== 1'b0) begin
            $display("FAIL mux_sel0_a: got %b expected 0", mux_out);
            n_fail++;
        end
        mux_sel = 1'b1;
        #1;
        n_checks++;
        if (mux_out !== 1'b1) begin
            $display("FAIL mux_sel1_a: got %b expected 1", mux_out);
            n_fail++;
        end
        mux_i0 = 1'b1; mux_i1 = 1'b0;
        #1;
        n_checks++;
        if (mux_out !== 1'b0) begin
            $display("FAIL mux_sel1_b: got %b expected 0", mux_out);
            n_fail++;
        end
        mux_sel = 1'b0;
        #1;
        n_checks++;
        if (mux_out !== 1'b1) begin
            $display("FAIL mux_sel0_b: got %b expected 1", mux_out);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset(1);
        cfg_we = 1'b1;
        cfg_data = 16'h8001;
        tick();
        cfg_we = 1'b0;
        cnt_en = 1'b1;
        repeat (13) tick();
        cnt_en = 1'b0;
        lut_in = 4'hF;
        #1;
        n_checks++;
        if (leds !== 5'd13 || lut_out !== 1'b1) begin
            $display("FAIL midrst_setup: got leds=%0d lut=%b expected leds=13 lut=1", leds, lut_out);
            n_fail++;
        end
        cnt_en = 1'b1;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (leds !== 5'd0) begin
            $display("FAIL midrst_leds: got %0d expected 0", leds);
            n_fail++;
        end
        n_checks++;
        if (lut_out !== 1'b0) begin
            $display("FAIL midrst_lut: got %b expected 0", lut_out);
            n_fail++;
        end
        // Mux still follows its inputs while reset is asserted.
        mux_sel = 1'b1; mux_i1 = 1'b1;
        #1;
        n_checks++;
        if (mux_out !== 1'b1) begin
            $display("FAIL midrst_mux1: got %b expected 1", mux_out);
            n_fail++;
        end
        mux_i1 = 1'b0;
        #1;
        n_checks++;
        if (mux_out !== 1'b0) begin
            $display("FAIL midrst_mux0: got %b expected 0", mux_out);
            n_fail++;
        end
        rst_n = 1'b1;
        cnt_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_counter();
        test_prescaler();
        test_lut();
        test_back_to_back();
        test_mux();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
